// File: rtl/pit8254_pkg.sv
// Shared types and helpers for the 8254 programming controller.
// Optional readback support is enabled with the PIT_READBACK_EN macro.
package pit8254_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_NEXT,
        ST_DONE
    } state_t;

    localparam logic [1:0] ADDR_CW  = 2'b11;

    localparam logic [1:0] RW_LATCH = 2'b00;
    localparam logic [1:0] RW_LSB   = 2'b01;
    localparam logic [1:0] RW_MSB   = 2'b10;
    localparam logic [1:0] RW_BOTH  = 2'b11;

    // BCD bit is always 0: counts are binary.
    function automatic logic [7:0] build_cw(input logic [1:0] sc,
                                            input logic [1:0] rw,
                                            input logic [2:0] mode);
        return {sc, rw, mode, 1'b0};
    endfunction

endpackage

// File: rtl/pit8254_prog_ctrl_pit_rr_arb.sv
// Round-robin arbiter: grants the first request at or after the pointer,
// and moves the pointer past the winner when the owner accepts the grant.
module pit_rr_arb #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic         any,
    output logic [N-1:0] grant,
    output logic [1:0]   grant_idx
);

    logic [1:0] ptr_reg;
    int         best;

    always_comb begin
        grant_idx = 2'd0;
        best      = N;
        for (int j = 0; j < N; j++) begin
            if (req[j] && (((j - int'(ptr_reg) + N) % N) < best)) begin
                best      = (j - int'(ptr_reg) + N) % N;
                grant_idx = 2'(j);
            end
        end
        any = |req;
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign grant[gi] = any && (grant_idx == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= 2'd0;
        end else if (advance && any) begin
            ptr_reg <= (grant_idx == 2'(N - 1)) ? 2'd0 : grant_idx + 2'd1;
        end
    end

endmodule

// File: rtl/pit8254_prog_ctrl.sv
// 8254 bus-side programming controller: arbitrates counter requesters and
// emits control-word / count-byte write cycles. Readback under PIT_READBACK_EN.
import pit8254_pkg::*;

module pit8254_prog_ctrl #(
    parameter int SETUP_CYC = 1,
    parameter int WR_CYC    = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [8:0]  req_mode,
    input  logic [5:0]  req_rw,
    input  logic [47:0] req_count,
`ifdef PIT_READBACK_EN
    input  logic        rb_req,
    input  logic [1:0]  rb_sel,
    input  logic [7:0]  data_in,
    output logic        rb_ack,
    output logic [15:0] rb_count,
`endif
    output logic [2:0]  ack,
    output logic        busy,
    output logic        cs_n,
    output logic        wr_n,
    output logic        rd_n,
    output logic        a0,
    output logic        a1,
    output logic [7:0]  data_out
);

    localparam int SETUP_N = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
    localparam int WR_N    = (WR_CYC    < 1) ? 1 : WR_CYC;
    localparam int HOLD_N  = (HOLD_CYC  < 1) ? 1 : HOLD_CYC;

`ifdef PIT_READBACK_EN
    localparam int NSLOT = 4;
    logic [NSLOT-1:0] arb_req;
    logic [7:0]       rb_lo_reg;
    logic [7:0]       rb_hi_reg;
    assign arb_req = {rb_req, req};
`else
    localparam int NSLOT = 3;
    logic [NSLOT-1:0] arb_req;
    assign arb_req = req;
    assign rd_n    = 1'b1;
`endif

    state_t           state_reg;
    logic [7:0]       cnt_reg;
    logic [1:0]       byte_reg;
    logic [1:0]       rw_reg;
    logic [1:0]       addr_reg;
    logic [15:0]      count_reg;
    logic [NSLOT-1:0] sel_reg;

    logic             arb_any;
    logic [NSLOT-1:0] arb_grant;
    logic [1:0]       arb_idx;

    pit_rr_arb #(.N(NSLOT)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (arb_req),
        .advance   (state_reg == ST_IDLE),
        .any       (arb_any),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    logic [2:0]  g_mode;
    logic [1:0]  g_rw;
    logic [15:0] g_count;
    logic [1:0]  g_addr;
    logic [7:0]  g_cw;

    always_comb begin
        g_mode  = req_mode[2:0];
        g_rw    = req_rw[1:0];
        g_count = req_count[15:0];
        case (arb_idx)
            2'd1: begin
                g_mode  = req_mode[5:3];
                g_rw    = req_rw[3:2];
                g_count = req_count[31:16];
            end
            2'd2: begin
                g_mode  = req_mode[8:6];
                g_rw    = req_rw[5:4];
                g_count = req_count[47:32];
            end
            default: ;
        endcase
        g_addr = arb_idx;
        g_cw   = build_cw(arb_idx, g_rw, g_mode);
`ifdef PIT_READBACK_EN
        // Readback reuses the byte engine: both "bytes" become read cycles.
        if (arb_grant[3]) begin
            g_rw    = RW_BOTH;
            g_count = 16'd0;
            g_addr  = rb_sel;
            g_cw    = build_cw(rb_sel, RW_LATCH, 3'b000);
        end
`endif
    end

    logic       nb_valid;
    logic [1:0] nb_idx;
    logic [7:0] nb_data;

    always_comb begin
        nb_valid = 1'b0;
        nb_idx   = 2'd0;
        if (byte_reg == 2'd0 && (rw_reg == RW_LSB || rw_reg == RW_BOTH)) begin
            nb_valid = 1'b1;
            nb_idx   = 2'd1;
        end else if (byte_reg != 2'd2 && (rw_reg == RW_MSB || rw_reg == RW_BOTH)) begin
            nb_valid = 1'b1;
            nb_idx   = 2'd2;
        end
        nb_data = (nb_idx == 2'd2) ? count_reg[15:8] : count_reg[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 8'd0;
            byte_reg  <= 2'd0;
            rw_reg    <= 2'd0;
            addr_reg  <= 2'd0;
            count_reg <= 16'd0;
            sel_reg   <= '0;
            cs_n      <= 1'b1;
            wr_n      <= 1'b1;
            a0        <= 1'b0;
            a1        <= 1'b0;
            data_out  <= 8'd0;
            ack       <= 3'd0;
            busy      <= 1'b0;
`ifdef PIT_READBACK_EN
            rd_n      <= 1'b1;
            rb_ack    <= 1'b0;
            rb_count  <= 16'd0;
            rb_lo_reg <= 8'd0;
            rb_hi_reg <= 8'd0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (arb_any) begin
                        sel_reg    <= arb_grant;
                        byte_reg   <= 2'd0;
                        rw_reg     <= g_rw;
                        addr_reg   <= g_addr;
                        count_reg  <= g_count;
                        cnt_reg    <= 8'(SETUP_N - 1);
                        {a1, a0}   <= ADDR_CW;
                        data_out   <= g_cw;
                        cs_n       <= 1'b0;
                        wr_n       <= 1'b1;
                        busy       <= 1'b1;
                        state_reg  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_reg == 8'd0) begin
                        cnt_reg   <= 8'(WR_N - 1);
                        state_reg <= ST_STROBE;
`ifdef PIT_READBACK_EN
                        if (sel_reg[3] && byte_reg != 2'd0)
                            rd_n <= 1'b0;
                        else
                            wr_n <= 1'b0;
`else
                        wr_n <= 1'b0;
`endif
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                ST_STROBE: begin
                    if (cnt_reg == 8'd0) begin
                        cnt_reg   <= 8'(HOLD_N - 1);
                        wr_n      <= 1'b1;
                        state_reg <= ST_HOLD;
`ifdef PIT_READBACK_EN
                        rd_n <= 1'b1;
                        if (sel_reg[3] && byte_reg == 2'd1)
                            rb_lo_reg <= data_in;
                        if (sel_reg[3] && byte_reg == 2'd2)
                            rb_hi_reg <= data_in;
`endif
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_reg == 8'd0) begin
                        cs_n      <= 1'b1;
                        state_reg <= ST_NEXT;
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                ST_NEXT: begin
                    if (nb_valid) begin
                        byte_reg  <= nb_idx;
                        cnt_reg   <= 8'(SETUP_N - 1);
                        {a1, a0}  <= addr_reg;
                        data_out  <= nb_data;
                        cs_n      <= 1'b0;
                        state_reg <= ST_SETUP;
                    end else begin
                        ack       <= sel_reg[2:0];
                        state_reg <= ST_DONE;
`ifdef PIT_READBACK_EN
                        rb_ack <= sel_reg[3];
                        if (sel_reg[3])
                            rb_count <= {rb_hi_reg, rb_lo_reg};
`endif
                    end
                end
                ST_DONE: begin
                    ack       <= 3'd0;
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
`ifdef PIT_READBACK_EN
                    rb_ack <= 1'b0;
`endif
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
